serial_negate_ctrl: RTL and testbench

SERIAL_NEGATE_CTRL -- requirements
Module: serial_negate_ctrl

---
 rtl/serial_negate_ctrl.sv | 104 ++++++++++
 tb/tb_serial_negate_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_negate_ctrl.sv
// Bit-serial two's-complement negate/pass-through with a valid/ready front and back end.
// One bit per clock, LSB first; the result is published only once the whole word is done.
module serial_negate_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_neg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         overflow,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    // Handshake rule for both ports: a word moves on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and a presented result holds until it moves.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_t        state, state_nx;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          mode;
    logic          seen_one;
    logic          ovf_flag;
    logic          accept;
    logic          transfer;
    logic          last_bit;
    logic          x;
    logic          rbit;

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign last_bit = (cnt == CW'(W - 1));
    assign x        = shreg[0];
    assign rbit     = mode ? (x ^ seen_one) : x;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    if (transfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
        overflow  = (state == DONE) && ovf_flag;
        state_dbg = state;
    end

    // Input bits leave at the LSB while result bits enter at the MSB, so after W steps
    // the same register holds the result with bit i at position i.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            seen_one <= 1'b0;
            ovf_flag <= 1'b0;
            out_data <= '0;
        end else if (accept) begin
            shreg    <= in_data;
            mode     <= in_neg;
            cnt      <= '0;
            seen_one <= 1'b0;
            ovf_flag <= in_neg && (in_data == MOST_NEG);
        end else if (state == SHIFT) begin
            shreg <= {rbit, shreg[W-1:1]};
            cnt   <= cnt + 1'b1;
            if (mode) begin
                seen_one <= seen_one | x;
            end
            if (last_bit) begin
                out_data <= {rbit, shreg[W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl (W=8): stimulus pushes expected {overflow, data}
// into a queue, and a monitor pops and compares on every output transfer.
module tb_serial_negate_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_neg;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         overflow;
    logic         busy;
    logic [1:0]   state_dbg;

    logic [W:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    serial_negate_ctrl #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: a transfer happens at the next edge when both are high mid-cycle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {23'd0, overflow, out_data}, 32'hDEAD);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, overflow, out_data}, {23'd0, e});
            end
        end
    end

    // Returns after the accept edge (+#1); n = cycles waited before in_ready was seen high.
    task automatic wait_accept(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(n), 32'd0);
                return;
            end
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic neg, input logic [W-1:0] exp_d,
                        input logic exp_ovf, output int n);
        in_valid = 1'b1;
        in_data  = d;
        in_neg   = neg;
        exp_q.push_back({exp_ovf, exp_d});
        wait_accept(n);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
        in_neg   = $urandom_range(0, 1);
    endtask

    // Counts edges after accept until out_valid; in_ready must stay low meanwhile.
    task automatic measure_latency(input string name);
        int k;
        int ready_seen;
        k = 0;
        ready_seen = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (in_ready) ready_seen++;
        end
        check({name, "_latency"}, 32'(k), 32'(W));
        check({name, "_in_ready_low"}, 32'(ready_seen), 32'd0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        int n;
        int k;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_neg    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);

        // First edge with reset low accepts immediately.
        reset = 1'b0;
        send(8'h05, 1'b1, 8'hFB, 1'b0, n);
        check("first_accept_wait", 32'(n), 32'd0);
        check("busy_in_shift", 32'(busy), 32'd1);
        measure_latency("neg05");
        wait_idle();

        send(8'h00, 1'b1, 8'h00, 1'b0, n);
        wait_idle();
        send(8'h80, 1'b1, 8'h80, 1'b1, n);
        measure_latency("neg80");
        check("ovf_in_done", 32'(overflow), 32'd1);
        wait_idle();
        send(8'h80, 1'b0, 8'h80, 1'b0, n);
        wait_idle();
        send(8'hFF, 1'b1, 8'h01, 1'b0, n);
        wait_idle();

        // Pass-through: in_ready low for cycles 1..9 after accept.
        send(8'h3C, 1'b0, 8'h3C, 1'b0, n);
        measure_latency("pass3c");
        check("in_ready_done", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_xfer", 32'(in_ready), 32'd1);

        // Backpressure.
        out_ready = 1'b0;
        send(8'h01, 1'b1, 8'hFF, 1'b0, n);
        measure_latency("bp01");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'hFF);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {30'd0, in_ready, busy}, 32'd2);

        // Reset during the 4th SHIFT cycle discards the word.
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_neg   = 1'b1;
        wait_accept(n);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        send(8'h7F, 1'b1, 8'h81, 1'b0, n);
        wait_idle();

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        in_data  = 8'h02;
        in_neg   = 1'b1;
        exp_q.push_back({1'b0, 8'hFE});
        wait_accept(n);
        in_data = 8'hFE;
        exp_q.push_back({1'b0, 8'h02});
        wait_accept(n);
        check("b2b_gap", 32'(n), 32'(W + 1));
        in_valid = 1'b0;
        wait_idle();

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
